// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads to instruction memory, holds the
// fetched word for decode, and handles redirects (write_pc) and halt.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'b111111
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        fnction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              write_pc,
    input  logic [ADDR_W-1:0] target,
    output logic              halted
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_DROP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] fetch_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            pc_out     <= RESET_PC;
            instr      <= '0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    // A redirect always wins over a completing read
                    if (write_pc) begin
                        pc <= target;
                        if (imem_ack) fetch_addr <= target;
                        else          state      <= S_DROP;
                    end else if (imem_ack) begin
                        instr  <= imem_rdata;
                        pc_out <= fetch_addr;
                        pc     <= fetch_addr + 1'b1;
                        state  <= S_HOLD;
                    end
                end
                S_DROP: begin
                    if (write_pc) pc <= target;
                    if (imem_ack) begin
                        fetch_addr <= write_pc ? target : pc;
                        state      <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (write_pc) begin
                        pc         <= target;
                        fetch_addr <= target;
                        state      <= S_REQ;
                    end else if (instr_ready) begin
                        if (opcode == HALT_OP) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            fetch_addr <= pc;
                            state      <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    if (write_pc) begin
                        pc         <= target;
                        fetch_addr <= target;
                        halted     <= 1'b0;
                        state      <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // The request is suppressed while reset is held so nothing escapes before release
    assign imem_req    = ((state == S_REQ) || (state == S_DROP)) && !rst;
    assign imem_addr   = fetch_addr;
    assign instr_valid = (state == S_HOLD);
    assign opcode      = instr[31:26];
    assign fnction     = instr[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized traffic checked
// against a transaction-level model of the fetch unit.
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  fnction;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] pc_out;
    logic        write_pc = 1'b0;
    logic [15:0] target = '0;
    logic        halted;

    instr_fetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instr(instr),
        .opcode(opcode), .fnction(fnction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc_out(pc_out), .write_pc(write_pc),
        .target(target), .halted(halted)
    );

    // Narrow instance starting at the top of its address space
    logic        rst_s = 1'b1;
    logic        imem_req_s;
    logic [3:0]  imem_addr_s;
    logic [31:0] imem_rdata_s = 32'h1234_5678;
    logic        imem_ack_s = 1'b0;
    logic [31:0] instr_s;
    logic [5:0]  opcode_s;
    logic [5:0]  fnction_s;
    logic        instr_valid_s;
    logic        instr_ready_s = 1'b0;
    logic [3:0]  pc_out_s;
    logic        write_pc_s = 1'b0;
    logic [3:0]  target_s = '0;
    logic        halted_s;

    instr_fetch #(.ADDR_W(4), .RESET_PC(4'hF)) dut_s (
        .clk(clk), .rst(rst_s), .imem_req(imem_req_s), .imem_addr(imem_addr_s),
        .imem_rdata(imem_rdata_s), .imem_ack(imem_ack_s), .instr(instr_s),
        .opcode(opcode_s), .fnction(fnction_s), .instr_valid(instr_valid_s),
        .instr_ready(instr_ready_s), .pc_out(pc_out_s), .write_pc(write_pc_s),
        .target(target_s), .halted(halted_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: where the next fetch goes, whether a live or a discarded read is
    // outstanding, whether a word is held for decode, and whether fetch is halted.
    logic [15:0] m_pc, m_addr, m_pcout;
    logic [31:0] m_instr;
    bit          m_live, m_discard, m_held, m_halt, m_after_rst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ack, input logic [31:0] rd,
                              input bit rdy, input bit wp, input logic [15:0] tg);
        if (r) begin
            m_pc = 16'h0; m_addr = 16'h0; m_pcout = 16'h0; m_instr = '0;
            m_live = 1; m_discard = 0; m_held = 0; m_halt = 0;
        end else if (m_halt) begin
            if (wp) begin m_pc = tg; m_addr = tg; m_live = 1; m_halt = 0; end
        end else if (m_held) begin
            if (wp) begin
                m_pc = tg; m_addr = tg; m_held = 0; m_live = 1;
            end else if (rdy) begin
                m_held = 0;
                if (m_instr[31:26] == 6'h3F) m_halt = 1;
                else begin m_addr = m_pc; m_live = 1; end
            end
        end else if (m_live) begin
            if (wp) begin
                m_pc = tg;
                if (ack) m_addr = tg;
                else begin m_live = 0; m_discard = 1; end
            end else if (ack) begin
                m_instr = rd; m_pcout = m_addr; m_pc = m_addr + 16'd1;
                m_live = 0; m_held = 1;
            end
        end else if (m_discard) begin
            if (wp) m_pc = tg;
            if (ack) begin m_discard = 0; m_live = 1; m_addr = m_pc; end
        end
        m_after_rst = r;
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model
    task automatic step(input bit r, input bit ack, input logic [31:0] rd,
                        input bit rdy, input bit wp, input logic [15:0] tg);
        rst = r; imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
        write_pc = wp; target = tg;
        #1;
        if (r && m_after_rst) begin
            chk("rst_req", {31'b0, imem_req}, 32'd0);
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
            chk("rst_halted", {31'b0, halted}, 32'd0);
            chk("rst_instr", instr, 32'd0);
            chk("rst_pc_out", {16'b0, pc_out}, 32'd0);
            chk("rst_addr", {16'b0, imem_addr}, 32'd0);
        end else if (!r) begin
            chk("req", {31'b0, imem_req}, {31'b0, m_live | m_discard});
            chk("valid", {31'b0, instr_valid}, {31'b0, m_held});
            chk("halted", {31'b0, halted}, {31'b0, m_halt});
            if (m_live | m_discard) chk("addr", {16'b0, imem_addr}, {16'b0, m_addr});
            if (m_held) begin
                chk("instr", instr, m_instr);
                chk("pc_out", {16'b0, pc_out}, {16'b0, m_pcout});
                chk("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
                chk("fnction", {26'b0, fnction}, {26'b0, m_instr[5:0]});
            end
        end
        @(posedge clk);
        model_edge(r, ack, rd, rdy, wp, tg);
        @(negedge clk);
    endtask

    initial begin
        m_after_rst = 0;
        @(negedge clk);

        // Narrow instance: fetch at 4'hF, then the next request wraps to 4'h0
        rst_s = 1'b1;
        @(negedge clk);
        rst_s = 1'b0; imem_ack_s = 1'b1; instr_ready_s = 1'b1;
        #1;
        chk("w_req0", {31'b0, imem_req_s}, 32'd1);
        chk("w_addr0", {28'b0, imem_addr_s}, 32'hF);
        @(negedge clk);
        chk("w_valid", {31'b0, instr_valid_s}, 32'd1);
        chk("w_pc_out", {28'b0, pc_out_s}, 32'hF);
        @(negedge clk);
        chk("w_req1", {31'b0, imem_req_s}, 32'd1);
        chk("w_addr1", {28'b0, imem_addr_s}, 32'h0);
        imem_ack_s = 1'b0; instr_ready_s = 1'b0;

        // Reset held two cycles
        step(1, 0, '0, 0, 0, '0);
        step(1, 1, 32'hDEAD_BEEF, 1, 1, 16'h5555);

        // Ack every cycle, decode always ready: sequential addresses
        for (int i = 0; i < 6; i++) step(0, 1, 32'h0000_1000 + i, 1, 0, '0);

        // Ack delayed three cycles
        for (int i = 0; i < 3; i++) step(0, 0, 32'hFFFF_FFFF, 1, 0, '0);
        step(0, 1, 32'h8C22_0004, 0, 0, '0);
        chk("op_lw", {26'b0, opcode}, 32'h23);
        chk("fn_lw", {26'b0, fnction}, 32'h04);

        // Decode stalls while held; acks are ignored
        for (int i = 0; i < 5; i++) step(0, i[0], 32'h1111_1111, 0, 0, '0);
        step(0, 0, '0, 1, 0, '0);

        // Redirect with the read still pending
        step(0, 0, '0, 0, 1, 16'h0040);
        step(0, 0, '0, 0, 0, '0);
        step(0, 1, 32'hBAD0_0000, 1, 0, '0);
        chk("redirect_addr", {16'b0, imem_addr}, 32'h0040);
        chk("redirect_valid", {31'b0, instr_valid}, 32'd0);

        // Halt instruction, then restart by redirect
        step(0, 1, 32'hFC00_0000, 0, 0, '0);
        step(0, 0, '0, 1, 0, '0);
        chk("halt_set", {31'b0, halted}, 32'd1);
        chk("halt_req", {31'b0, imem_req}, 32'd0);
        step(0, 1, 32'h2222_2222, 1, 0, '0);
        step(0, 0, '0, 0, 1, 16'h0010);
        chk("halt_clear", {31'b0, halted}, 32'd0);
        chk("restart_addr", {16'b0, imem_addr}, 32'h0010);

        // Redirect coinciding with ack, then repeated redirects while dropping
        step(0, 1, 32'h3333_3333, 0, 1, 16'h0100);
        step(0, 0, '0, 0, 1, 16'h0200);
        step(0, 0, '0, 0, 1, 16'h0300);
        step(0, 1, 32'h4444_4444, 0, 0, '0);
        chk("last_target", {16'b0, imem_addr}, 32'h0300);

        // Reset mid-request; a stale ack afterwards completes the new request
        step(0, 0, '0, 0, 0, '0);
        step(1, 0, '0, 0, 0, '0);
        step(0, 1, 32'h5555_0001, 0, 0, '0);
        step(0, 0, '0, 1, 0, '0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rd;
            rd = $urandom;
            if ($urandom_range(0, 7) == 0) rd[31:26] = 6'h3F;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, rd,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0, 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter ADDR_W, default 16: width of the word address (PC).
REQ-002 Parameter RESET_PC, default 0: PC value loaded by reset.
REQ-003 Parameter HALT_OP, default 6'b111111: opcode field value that identifies the halt instruction.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  ADDR_W  word address of the current request.
REQ-008 imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-009 imem_ack  input  1  read completes this cycle.
REQ-010 instr  output  32  held instruction word.
REQ-011 opcode  output  6  instr[31:26], to control unit.
REQ-012 fnction  output  6  instr[5:0], to control unit.
REQ-013 instr_valid  output  1  instr/opcode/fnction/pc_out are valid.
REQ-014 instr_ready  input  1  decode accepts the held instruction.
REQ-015 pc_out  output  ADDR_W  address of the held instruction.
REQ-016 write_pc  input  1  redirect pulse (branch taken, jump, call, return).
REQ-017 target  input  ADDR_W  redirect address; sampled when write_pc=1.
REQ-018 halted  output  1  fetch stopped on a halt instruction.

Function
REQ-019 The block SHALL implement the states REQ, DROP, HOLD and HALT, plus the registers pc and fetch_addr.
REQ-020 On entry to REQ, fetch_addr SHALL load pc; imem_addr SHALL equal fetch_addr at all times.
REQ-021 In REQ and DROP, imem_req SHALL be 1, with imem_addr constant until ack; in HOLD and HALT, imem_req SHALL be 0.
REQ-022 imem_ack SHALL be ignored in HOLD and HALT.
REQ-023 REQ with ack and no write_pc: instr<=imem_rdata, pc_out<=fetch_addr, pc<=fetch_addr+1 modulo 2^ADDR_W, then go to HOLD.
REQ-024 Ack may arrive in the first REQ cycle, giving instr_valid=1 on the next cycle (1-cycle minimum latency).
REQ-025 instr_valid SHALL be 1 exactly while in HOLD; instr and pc_out SHALL stay stable throughout HOLD.
REQ-026 HOLD with instr_ready and no write_pc: if opcode==HALT_OP go to HALT, else go to REQ; no request is issued in the accept cycle.
REQ-027 HOLD with write_pc: pc<=target, the held instruction is discarded (instr_valid=0 next cycle), then go to REQ; write_pc takes priority over instr_ready.
REQ-028 REQ with write_pc and ack in the same cycle: rdata discarded, pc<=target, instr unchanged, stay in REQ with fetch_addr reloaded to target next cycle.
REQ-029 REQ with write_pc and no ack: pc<=target, go to DROP; DROP holds the old imem_addr until ack, discards rdata, then goes to REQ.
REQ-030 A write_pc during DROP SHALL overwrite pc; the last target wins.
REQ-031 HALT: halted=1 and instr_valid=0; write_pc SHALL set pc<=target, clear halted and go to REQ.
REQ-032 opcode and fnction SHALL be continuous slices of instr.
REQ-033 pc increment SHALL wrap from 2^ADDR_W-1 to 0 without error.

Reset
REQ-034 While rst=1 at a clock edge: pc<=RESET_PC, fetch_addr<=RESET_PC, pc_out<=RESET_PC, instr<=0, state<=REQ, halted<=0.
REQ-035 imem_req and instr_valid SHALL be 0 in the cycle following a reset edge only while rst stays 1.
REQ-036 The first request (imem_addr=RESET_PC) SHALL be issued in the first cycle with rst=0.
REQ-037 Reset mid-transaction SHALL abandon the outstanding request with no DROP; a stale ack after reset is treated as the ack of the new request.

Verification
REQ-038 Reset release, ack every cycle, instr_ready=1 -> imem_addr 0,1,2,...; instr_valid every second cycle; pc_out matches each fetched address.
REQ-039 Ack delayed 3 cycles with rdata=32'h8C22_0004 -> imem_req high for 4 cycles at constant address; opcode=6'h23 and fnction=6'h04 after ack.
REQ-040 instr_ready=0 for 5 cycles in HOLD -> instr_valid stays 1, instr stable, imem_req=0.
REQ-041 write_pc target=16'h0040 in REQ with ack pending 2 cycles -> old ack discarded, next request at 16'h0040, no instr_valid for the old word.
REQ-042 Fetch of a word with opcode 6'h3F, accepted -> halted=1, imem_req=0; then write_pc target=16'h0010 -> halted=0 and request at 16'h0010.
REQ-043 ADDR_W=4, fetch at address 4'hF -> next request at 4'h0.
